endpoint_resp_table: RTL and testbench

- Receive-side counterpart of the endpoint's outgoing message table.
- Accepts incoming request headers from the endpoint RX path and holds each one in a slot.
- Dispatches slots one at a time to the local request processor, collects completion status, and issues response headers to the TX path.
- Frees each slot after its response handshake completes.

---
 rtl/endpoint_resp_table.sv | 250 +++++++++++++++++++++++++
 tb/tb_endpoint_resp_table.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/endpoint_resp_table.sv
// -----------------------------------------------------------------------------
// endpoint_resp_table
//
// Receive-side request table. Incoming request headers are parked in a slot,
// handed one at a time to the local request processor, marked complete when
// the processor reports a status, and returned to the TX path as response
// headers. A slot is released once its response has been accepted.
//
// Slot lifecycle: FREE -> RECEIVED -> PROCESSING -> DONE -> FREE
//
// Ports
//   clk, n_rst                     clock, asynchronous active-low reset
//   req_valid/req_ready            incoming request header handshake
//   req_src, req_tag, req_len      request header fields
//   disp_valid/disp_ready          dispatch handshake to the processor
//   disp_slot/src/tag/len          offered slot and its stored fields
//   done_valid, done_slot,         completion strobe from the processor
//   done_status                    (0=OK, 1=ERR, 2=UNSUP, 3=RSVD)
//   resp_valid/resp_ready          response header handshake to TX
//   resp_dest/tag/status           response header fields
//   occupancy                      number of non-FREE slots
//   dup_err                        pulse: duplicate (src,tag) request dropped
//   done_err                       pulse: completion to a non-PROCESSING slot
// -----------------------------------------------------------------------------
module endpoint_resp_table #(
    parameter int NUM_SLOTS = 4,
    parameter int ID_W      = 5,
    parameter int TAG_W     = 4,
    parameter int LEN_W     = 8,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_src,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [LEN_W-1:0]  req_len,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [SLOT_W-1:0] disp_slot,
    output logic [ID_W-1:0]   disp_src,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [LEN_W-1:0]  disp_len,
    input  logic              done_valid,
    input  logic [SLOT_W-1:0] done_slot,
    input  logic [1:0]        done_status,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ID_W-1:0]   resp_dest,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [1:0]        resp_status,
    output logic [SLOT_W:0]   occupancy,
    output logic              dup_err,
    output logic              done_err
);

    typedef enum logic [1:0] {
        ST_FREE       = 2'd0,
        ST_RECEIVED   = 2'd1,
        ST_PROCESSING = 2'd2,
        ST_DONE       = 2'd3
    } slot_state_e;

    slot_state_e        state_r  [NUM_SLOTS];
    logic [ID_W-1:0]    src_r    [NUM_SLOTS];
    logic [TAG_W-1:0]   tag_r    [NUM_SLOTS];
    logic [LEN_W-1:0]   len_r    [NUM_SLOTS];
    logic [1:0]         status_r [NUM_SLOTS];

    logic               disp_lock_r;
    logic [SLOT_W-1:0]  disp_lock_slot_r;
    logic               resp_lock_r;
    logic [SLOT_W-1:0]  resp_lock_slot_r;
    logic [SLOT_W:0]    occupancy_r;
    logic               dup_err_r;
    logic               done_err_r;

    logic [NUM_SLOTS-1:0] free_vec_s;
    logic [NUM_SLOTS-1:0] recv_vec_s;
    logic [NUM_SLOTS-1:0] done_vec_s;
    logic [NUM_SLOTS-1:0] match_vec_s;
    logic [SLOT_W-1:0]    alloc_slot_s;
    logic [SLOT_W-1:0]    disp_slot_s;
    logic [SLOT_W-1:0]    resp_slot_s;
    logic                 req_fire_s;
    logic                 dup_s;
    logic                 alloc_s;
    logic                 disp_fire_s;
    logic                 resp_fire_s;
    logic                 done_legal_s;

    // Lowest set bit index of a slot vector; zero when the vector is empty.
    function automatic logic [SLOT_W-1:0] lowest_idx(input logic [NUM_SLOTS-1:0] vec);
        logic [SLOT_W-1:0] idx;
        idx = {SLOT_W{1'b0}};
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SLOT_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Classify every slot by state and look for an in-flight (src,tag) match.
    always_comb begin
        free_vec_s  = {NUM_SLOTS{1'b0}};
        recv_vec_s  = {NUM_SLOTS{1'b0}};
        done_vec_s  = {NUM_SLOTS{1'b0}};
        match_vec_s = {NUM_SLOTS{1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_vec_s[i]  = (state_r[i] == ST_FREE);
            recv_vec_s[i]  = (state_r[i] == ST_RECEIVED);
            done_vec_s[i]  = (state_r[i] == ST_DONE);
            match_vec_s[i] = (state_r[i] != ST_FREE) &&
                             (src_r[i] == req_src) && (tag_r[i] == req_tag);
        end
    end

    // Handshake decode. Valid/ready outputs come only from registered state so
    // neither side of any handshake sees a combinational loop.
    always_comb begin
        alloc_slot_s = lowest_idx(free_vec_s);
        req_ready    = |free_vec_s;
        req_fire_s   = req_valid && req_ready;
        dup_s        = |match_vec_s;
        alloc_s      = req_fire_s && !dup_s;

        // A held offer keeps its slot; otherwise the lowest candidate falls through.
        disp_slot_s  = disp_lock_r ? disp_lock_slot_r : lowest_idx(recv_vec_s);
        disp_valid   = disp_lock_r || (|recv_vec_s);
        disp_fire_s  = disp_valid && disp_ready;

        resp_slot_s  = resp_lock_r ? resp_lock_slot_r : lowest_idx(done_vec_s);
        resp_valid   = resp_lock_r || (|done_vec_s);
        resp_fire_s  = resp_valid && resp_ready;

        done_legal_s = done_valid && (state_r[done_slot] == ST_PROCESSING);
    end

    // Output field muxes driven from the slot registers.
    always_comb begin
        disp_slot   = disp_slot_s;
        disp_src    = src_r[disp_slot_s];
        disp_tag    = tag_r[disp_slot_s];
        disp_len    = len_r[disp_slot_s];
        resp_dest   = src_r[resp_slot_s];
        resp_tag    = tag_r[resp_slot_s];
        resp_status = status_r[resp_slot_s];
        occupancy   = occupancy_r;
        dup_err     = dup_err_r;
        done_err    = done_err_r;
    end

    // Per-slot lifecycle; each state accepts only its own event, so one slot
    // never sees two transitions in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_r[i] <= ST_FREE;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                case (state_r[i])
                    ST_FREE: begin
                        if (alloc_s && (alloc_slot_s == SLOT_W'(i))) begin
                            state_r[i] <= ST_RECEIVED;
                        end
                    end
                    ST_RECEIVED: begin
                        if (disp_fire_s && (disp_slot_s == SLOT_W'(i))) begin
                            state_r[i] <= ST_PROCESSING;
                        end
                    end
                    ST_PROCESSING: begin
                        if (done_legal_s && (done_slot == SLOT_W'(i))) begin
                            state_r[i] <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (resp_fire_s && (resp_slot_s == SLOT_W'(i))) begin
                            state_r[i] <= ST_FREE;
                        end
                    end
                    default: begin
                        state_r[i] <= ST_FREE;
                    end
                endcase
            end
        end
    end

    // Slot payload: header fields at allocation, status at completion.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                src_r[i]    <= {ID_W{1'b0}};
                tag_r[i]    <= {TAG_W{1'b0}};
                len_r[i]    <= {LEN_W{1'b0}};
                status_r[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (alloc_s && (alloc_slot_s == SLOT_W'(i))) begin
                    src_r[i] <= req_src;
                    tag_r[i] <= req_tag;
                    len_r[i] <= req_len;
                end
                if (done_legal_s && (done_slot == SLOT_W'(i))) begin
                    status_r[i] <= done_status;
                end
            end
        end
    end

    // Offer locks: once an offer stalls, pin its slot until it is taken.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            disp_lock_r      <= 1'b0;
            disp_lock_slot_r <= {SLOT_W{1'b0}};
            resp_lock_r      <= 1'b0;
            resp_lock_slot_r <= {SLOT_W{1'b0}};
        end else begin
            disp_lock_r      <= disp_valid && !disp_ready;
            disp_lock_slot_r <= disp_slot_s;
            resp_lock_r      <= resp_valid && !resp_ready;
            resp_lock_slot_r <= resp_slot_s;
        end
    end

    // Occupancy counter and registered error pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            occupancy_r <= {(SLOT_W + 1){1'b0}};
            dup_err_r   <= 1'b0;
            done_err_r  <= 1'b0;
        end else begin
            case ({alloc_s, resp_fire_s})
                2'b10:   occupancy_r <= occupancy_r + {{SLOT_W{1'b0}}, 1'b1};
                2'b01:   occupancy_r <= occupancy_r - {{SLOT_W{1'b0}}, 1'b1};
                default: occupancy_r <= occupancy_r;
            endcase
            dup_err_r  <= req_fire_s && dup_s;
            done_err_r <= done_valid && !done_legal_s;
        end
    end

endmodule

// File: tb/tb_endpoint_resp_table.sv
// -----------------------------------------------------------------------------
// tb_endpoint_resp_table
//
// Directed scenarios followed by randomized traffic. Expected outputs come from
// a slot-table model holding per-slot flags (busy / dispatched / completed) and
// the two "offer pinned" memories; the model is stepped once per clock.
// -----------------------------------------------------------------------------
module tb_endpoint_resp_table;

    localparam int NUM_SLOTS = 4;
    localparam int ID_W      = 5;
    localparam int TAG_W     = 4;
    localparam int LEN_W     = 8;
    localparam int SLOT_W    = 2;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_src;
    logic [TAG_W-1:0]  req_tag;
    logic [LEN_W-1:0]  req_len;
    logic              disp_valid;
    logic              disp_ready;
    logic [SLOT_W-1:0] disp_slot;
    logic [ID_W-1:0]   disp_src;
    logic [TAG_W-1:0]  disp_tag;
    logic [LEN_W-1:0]  disp_len;
    logic              done_valid;
    logic [SLOT_W-1:0] done_slot;
    logic [1:0]        done_status;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_dest;
    logic [TAG_W-1:0]  resp_tag;
    logic [1:0]        resp_status;
    logic [SLOT_W:0]   occupancy;
    logic              dup_err;
    logic              done_err;

    endpoint_resp_table #(
        .NUM_SLOTS(NUM_SLOTS), .ID_W(ID_W), .TAG_W(TAG_W), .LEN_W(LEN_W), .SLOT_W(SLOT_W)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_tag(req_tag), .req_len(req_len),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_slot(disp_slot),
        .disp_src(disp_src), .disp_tag(disp_tag), .disp_len(disp_len),
        .done_valid(done_valid), .done_slot(done_slot), .done_status(done_status),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dest(resp_dest), .resp_tag(resp_tag), .resp_status(resp_status),
        .occupancy(occupancy), .dup_err(dup_err), .done_err(done_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    bit m_busy [NUM_SLOTS];
    bit m_disp [NUM_SLOTS];
    bit m_cmpl [NUM_SLOTS];
    int m_src  [NUM_SLOTS];
    int m_tag  [NUM_SLOTS];
    int m_len  [NUM_SLOTS];
    int m_stat [NUM_SLOTS];
    bit m_dpin;
    int m_dpin_slot;
    bit m_rpin;
    int m_rpin_slot;
    int m_occ;
    bit m_dup_pulse;
    bit m_derr_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_busy[i] = 1'b0; m_disp[i] = 1'b0; m_cmpl[i] = 1'b0;
            m_src[i] = 0; m_tag[i] = 0; m_len[i] = 0; m_stat[i] = 0;
        end
        m_dpin = 1'b0; m_dpin_slot = 0;
        m_rpin = 1'b0; m_rpin_slot = 0;
        m_occ = 0; m_dup_pulse = 1'b0; m_derr_pulse = 1'b0;
    endtask

    // kind 0: empty slot, 1: waiting for dispatch, 2: finished awaiting response.
    function automatic int pick(input int kind);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (kind == 0 && !m_busy[i]) return i;
            if (kind == 1 && m_busy[i] && !m_disp[i]) return i;
            if (kind == 2 && m_busy[i] && m_cmpl[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_idle();
        req_valid = 1'b0; req_src = '0; req_tag = '0; req_len = '0;
        disp_ready = 1'b0; done_valid = 1'b0; done_slot = '0; done_status = 2'd0;
        resp_ready = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input bit rv, input int src, input int tag, input int len,
                        input bit dr, input bit dv, input int dslot, input int dstat,
                        input bit rr);
        int  a_slot, e_ds, e_rs;
        bit  e_rr, e_dv, e_rv, match, dup, alloc, legal;
        @(negedge clk);
        req_valid = rv; req_src = ID_W'(src); req_tag = TAG_W'(tag); req_len = LEN_W'(len);
        disp_ready = dr; done_valid = dv; done_slot = SLOT_W'(dslot);
        done_status = 2'(dstat); resp_ready = rr;
        #1;
        a_slot = pick(0);
        e_rr   = (a_slot >= 0);
        e_ds   = m_dpin ? m_dpin_slot : pick(1);
        e_dv   = (e_ds >= 0);
        e_rs   = m_rpin ? m_rpin_slot : pick(2);
        e_rv   = (e_rs >= 0);

        check("req_ready", 32'(req_ready), 32'(e_rr));
        check("disp_valid", 32'(disp_valid), 32'(e_dv));
        check("resp_valid", 32'(resp_valid), 32'(e_rv));
        if (e_dv) begin
            check("disp_slot", 32'(disp_slot), 32'(e_ds));
            check("disp_src", 32'(disp_src), 32'(m_src[e_ds]));
            check("disp_tag", 32'(disp_tag), 32'(m_tag[e_ds]));
            check("disp_len", 32'(disp_len), 32'(m_len[e_ds]));
        end
        if (e_rv) begin
            check("resp_dest", 32'(resp_dest), 32'(m_src[e_rs]));
            check("resp_tag", 32'(resp_tag), 32'(m_tag[e_rs]));
            check("resp_status", 32'(resp_status), 32'(m_stat[e_rs]));
        end
        check("occupancy", 32'(occupancy), 32'(m_occ));
        check("dup_err", 32'(dup_err), 32'(m_dup_pulse));
        check("done_err", 32'(done_err), 32'(m_derr_pulse));

        // Decide every event from the state before this edge, then apply.
        match = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_busy[i] && m_src[i] == src && m_tag[i] == tag) match = 1'b1;
        end
        dup   = rv && e_rr && match;
        alloc = rv && e_rr && !match;
        legal = dv && m_busy[dslot] && m_disp[dslot] && !m_cmpl[dslot];

        if (e_dv) begin
            if (dr) begin m_disp[e_ds] = 1'b1; m_dpin = 1'b0; end
            else    begin m_dpin = 1'b1; m_dpin_slot = e_ds; end
        end
        if (e_rv) begin
            if (rr) begin
                m_busy[e_rs] = 1'b0; m_disp[e_rs] = 1'b0; m_cmpl[e_rs] = 1'b0;
                m_rpin = 1'b0; m_occ--;
            end else begin
                m_rpin = 1'b1; m_rpin_slot = e_rs;
            end
        end
        if (legal) begin m_cmpl[dslot] = 1'b1; m_stat[dslot] = dstat; end
        if (alloc) begin
            m_busy[a_slot] = 1'b1; m_src[a_slot] = src; m_tag[a_slot] = tag;
            m_len[a_slot] = len; m_occ++;
        end
        m_dup_pulse  = dup;
        m_derr_pulse = dv && !legal;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_dup_err", 32'(dup_err), 32'd0);
        check("rst_done_err", 32'(done_err), 32'd0);
        model_clear();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        int dslot, cand;
        bit dv;
        n_rst = 1'b0;
        drive_idle();
        model_clear();
        do_reset();

        // Single request round trip
        step(1, 3, 5, 8, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill all slots, fifth request must stall
        for (int i = 0; i < NUM_SLOTS; i++) step(1, i + 4, i, 16 + i, 0, 0, 0, 0, 0);
        step(1, 9, 9, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 10, 2, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Slot 0 refills while the stalled dispatch offer stays on slot 2
        step(1, 10, 2, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Response pin: slot 2 offered first, slot 1 completes behind it
        step(0, 0, 0, 0, 0, 1, 2, 2, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Duplicate request
        do_reset();
        step(1, 2, 1, 4, 0, 0, 0, 0, 0);
        step(1, 2, 1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Illegal completions: FREE slot, then RECEIVED slot
        step(0, 0, 0, 0, 0, 1, 3, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Mixed states then reset: no responses may follow
        step(1, 4, 4, 3, 1, 0, 0, 0, 0);
        step(1, 5, 5, 3, 0, 1, 0, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 1);

        // Randomized traffic with a reset in the middle
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            dv    = ($urandom_range(0, 2) != 0);
            dslot = $urandom_range(0, NUM_SLOTS - 1);
            if ($urandom_range(0, 3) != 0) begin
                cand = -1;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (m_busy[i] && m_disp[i] && !m_cmpl[i] && ($urandom_range(0, 1) == 1 || cand < 0))
                        cand = i;
                end
                if (cand >= 0) dslot = cand;
            end
            step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 255), ($urandom_range(0, 2) != 0), dv, dslot,
                 $urandom_range(0, 3), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
